lsu: RTL and testbench
======================

# lsu

Load/store unit for the single-issue RV32IM core, directly downstream of the ALU. It takes the effective address the ALU produced for a load or store, drives the data-memory request/grant/response bus, and returns sign- or zero-extended load data for writeback. Its `busy` output stalls the execute stage in the same way the ALU's multiply `busy` does.

## Interface
Parameters:
- None. Address and data widths are fixed at 32.

Ports:
- `s_clk` (in, 1): single clock, rising edge.
- `s_reset` (in, 1): asynchronous, active-low reset.
- `req_valid` (in, 1): execute stage presents a memory instruction. It is held stable while `busy` is high.
- `is_load`, `is_store` (in, 1 each): operation kind. They are mutually exclusive.
- `funct3` (in, 3): load encodings are LB 000, LH 001, LW 010, LBU 100, LHU 101. Store encodings are SB 000, SH 001, SW 010.
- `addr` (in, 32): effective address, equal to the ALU result.
- `store_data` (in, 32): rs2 value.
- `rd_addr` (in, 5): load destination register.
- `busy` (out, 1): stall request to the execute stage.
- `done` (out, 1): one-cycle completion pulse.
- `wb_valid` (out, 1): load data is valid this cycle.
- `wb_rd` (out, 5): destination register for the load data.
- `wb_data` (out, 32): load data after extension.
- `misaligned` (out, 1): misaligned-access exception pulse.
- `exc_addr` (out, 32): faulting address.
- `mem_req` (out, 1): memory bus request.
- `mem_we` (out, 1): write enable.
- `mem_addr` (out, 32): word-aligned address, bits [1:0] = 00.
- `mem_be` (out, 4): byte enables.
- `mem_wdata` (out, 32): write data.
- `mem_gnt` (in, 1): request accepted.
- `mem_rvalid` (in, 1): read data valid.
- `mem_rdata` (in, 32): read data.

## Operation
- FSM states are IDLE, REQ, WAIT_RSP and DONE.
- IDLE:
  - A request is accepted when `req_valid && (is_load || is_store)`.
  - On acceptance the block captures `addr`, `funct3`, the op kind, `rd_addr`, and the lane-shifted store data and byte enables, then moves to REQ.
  - An illegal `funct3` (loads 011/110/111, stores 011 or above) moves directly to DONE with no bus access.
- REQ:
  - `mem_req` = 1; `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are driven from the captured registers and held stable until `mem_gnt`.
  - A store with `mem_gnt` goes to DONE. A load with `mem_gnt` goes to WAIT_RSP.
- WAIT_RSP:
  - `mem_req` = 0.
  - On `mem_rvalid`, the block extracts the byte or halfword at offset `addr[1:0]`, extends it, registers it into `wb_data`, and goes to DONE.
- DONE:
  - `done` = 1.
  - For a successful load, `wb_valid` = 1 and `wb_rd` = the captured rd. `wb_valid` is also asserted when rd is 0; the regfile ignores writes to x0.
  - Always returns to IDLE. `req_valid` seen in DONE belongs to the finishing instruction and is ignored.
- Store lanes:
  - SB: `mem_be` = 0001 shifted left by `addr[1:0]`; `mem_wdata` = byte replicated ×4.
  - SH: `mem_be` = 1100 if `addr[1]` else 0011; `mem_wdata` = halfword replicated ×2.
  - SW: `mem_be` = 1111.
- Load extension: LB and LH sign-extend. LBU and LHU zero-extend. LW passes the word through.
- `busy` = (IDLE and a request is being accepted) or state ∈ {REQ, WAIT_RSP}. It is combinational so the stall takes effect in the acceptance cycle. It is low in DONE.
- `mem_rvalid` outside WAIT_RSP is ignored.
- Reset values are 0 for every output and IDLE for the state. An assertion of reset mid-operation drops `mem_req` asynchronously and abandons the access.

## Timing
- Store with `mem_gnt` in its first REQ cycle: accept cycle, then REQ, then DONE. `done` arrives 2 cycles after acceptance.
- Load with grant in the first REQ cycle and `rvalid` in the next cycle: `wb_valid` arrives 3 cycles after acceptance.
- Every grant wait cycle and every response wait cycle adds exactly one cycle.
- The memory returns `mem_rvalid` no earlier than the cycle after `mem_gnt`, and at most one load is outstanding at a time.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access is LH/LHU/SH with `addr[0]`, or LW/SW with `addr[1:0]` ≠ 0.
  - Such an access goes IDLE to DONE with no `mem_req`.
  - In DONE, `misaligned` = 1, `exc_addr` = `addr`, `wb_valid` = 0.
- Macro undefined:
  - The `misaligned` and `exc_addr` outputs are tied to 0.
  - Offending address bits are ignored: the halfword offset uses `addr[1]` only, and word accesses use `addr[1:0]` = 00.

## Structure
- `cpu_pkg` holds:
  - the funct3 load/store encoding constants;
  - the `lsu_state_t` enum.
- Sub-module `lsu_align` is purely combinational and contains:
  - the store lane-shift and byte-enable generation;
  - the load byte/halfword extraction and extension.
- The FSM and the capture registers stay in `lsu`.

## Test plan
- SW to 0x100 with data 0xDEADBEEF, grant immediate:
  - `mem_addr` = 0x100, `mem_be` = 1111, `mem_wdata` = 0xDEADBEEF, `mem_we` = 1.
  - `done` 2 cycles after acceptance; `wb_valid` stays 0.
- SB to 0x203 with data 0x000000A5: `mem_addr` = 0x200, `mem_be` = 1000, `mem_wdata` = 0xA5A5A5A5.
- LB to 0x101 with rdata 0x12348056: `wb_data` = 0xFFFFFF80. The same access as LBU gives `wb_data` = 0x00000080.
- LH to 0x102 with `mem_gnt` delayed 3 cycles and rdata 0x80011234:
  - `mem_req` and the address stay stable and `busy` stays high through the delay.
  - `wb_data` = 0xFFFF8001, `wb_rd` matches the request.
- LW to 0x102:
  - With the macro: `misaligned` = 1, `exc_addr` = 0x102, and `mem_req` is never asserted.
  - Without the macro: `mem_addr` = 0x100, `misaligned` = 0.
- Reset asserted in WAIT_RSP: `mem_req`, `busy` and `wb_valid` go to 0 immediately and the FSM is in IDLE. A stray `mem_rvalid` after release produces no `wb_valid`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV32IM core definitions used by the load/store unit.
// Holds funct3 load/store encodings, LSU state enum and decode helpers.
package cpu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } lsu_state_t;

  function automatic logic ld_legal(logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic st_legal(logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

  // Halfword needs addr[0]=0, word needs addr[1:0]=0.
  function automatic logic is_misaligned(logic [2:0] f3,
                                         logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) ||
           ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit:
// store byte-enable/data replication and load extraction/extension.
module lsu_align
  import cpu_pkg::*;
(
  input  logic [2:0]  st_f3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  input  logic [2:0]  ld_f3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [31:0] shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign shifted = rdata >> {ld_off, 3'b000};
  assign ld_byte = shifted[7:0];
  assign ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];

  // Store lanes: replicate data, enable only the addressed bytes.
  always_comb begin
    be    = 4'b0000;
    wdata = st_data;
    unique case (st_f3)
      F3_SB: begin
        be    = 4'b0001 << st_off;
        wdata = {4{st_data[7:0]}};
      end
      F3_SH: begin
        be    = st_off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data[15:0]}};
      end
      F3_SW: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Load extraction with sign or zero extension.
  always_comb begin
    ldata = rdata;
    unique case (ld_f3)
      F3_LB:   ldata = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  ldata = {24'h0, ld_byte};
      F3_LH:   ldata = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  ldata = {16'h0, ld_half};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: request/grant/response data-memory master.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu
  import cpu_pkg::*;
(
  input  logic        s_clk,
  input  logic        s_reset,
  input  logic        req_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_addr,
  output logic        busy,
  output logic        done,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misaligned,
  output logic [31:0] exc_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state, state_nxt;
  logic        accept, legal, mis, skip;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  f3_q;
  logic        load_q, err_q;
  logic [4:0]  rd_q;
  logic [3:0]  be_q;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ldata;

  // Reset gates acceptance so busy is low while reset is held.
  assign accept = s_reset && req_valid && (is_load || is_store);
  assign legal  = is_load ? ld_legal(funct3) : st_legal(funct3);
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis    = legal && is_misaligned(funct3, addr[1:0]);
`else
  assign mis    = 1'b0;
`endif
  assign skip   = !legal || mis;

  lsu_align u_align (
    .st_f3   (funct3),
    .st_off  (addr[1:0]),
    .st_data (store_data),
    .ld_f3   (f3_q),
    .ld_off  (addr_q[1:0]),
    .rdata   (mem_rdata),
    .be      (be_d),
    .wdata   (wdata_d),
    .ldata   (ldata)
  );

  // State register.
  always_ff @(posedge s_clk or negedge s_reset) begin
    if (!s_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (accept) state_nxt = skip ? DONE : REQ;
      REQ:      if (mem_gnt) state_nxt = load_q ? WAIT_RSP : DONE;
      WAIT_RSP: if (mem_rvalid) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Capture the request at acceptance and the load result on rvalid.
  always_ff @(posedge s_clk or negedge s_reset) begin
    if (!s_reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
      be_q    <= '0;
      wb_data <= '0;
    end else begin
      if (state == IDLE && accept) begin
        addr_q  <= addr;
        wdata_q <= wdata_d;
        f3_q    <= funct3;
        load_q  <= is_load;
        err_q   <= skip;
        rd_q    <= rd_addr;
        be_q    <= be_d;
      end
      if (state == WAIT_RSP && mem_rvalid) wb_data <= ldata;
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    unique case (state)
      IDLE: busy = accept;
      REQ: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = !load_q;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_be    = be_q;
        mem_wdata = wdata_q;
      end
      WAIT_RSP: busy = 1'b1;
      DONE: begin
        done     = 1'b1;
        wb_valid = load_q && !err_q;
        wb_rd    = (load_q && !err_q) ? rd_q : 5'd0;
      end
      default: busy = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;

  // Remember that the pending DONE is a misalignment trap.
  always_ff @(posedge s_clk or negedge s_reset) begin
    if (!s_reset)                    mis_q <= 1'b0;
    else if (state == IDLE && accept) mis_q <= mis;
  end

  assign misaligned = (state == DONE) && mis_q;
  assign exc_addr   = misaligned ? addr_q : 32'h0;
`else
  assign misaligned = 1'b0;
  assign exc_addr   = 32'h0;
`endif

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for the load/store unit.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined.
module tb_lsu;

  logic        s_clk = 1'b0;
  logic        s_reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  rd_addr = '0;
  logic        busy, done, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misaligned;
  logic [31:0] exc_addr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  lsu dut (
    .s_clk      (s_clk),
    .s_reset    (s_reset),
    .req_valid  (req_valid),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .rd_addr    (rd_addr),
    .busy       (busy),
    .done       (done),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .misaligned (misaligned),
    .exc_addr   (exc_addr),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 s_clk = ~s_clk;

  task automatic step();
    @(posedge s_clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] rd);
    req_valid  = 1'b1;
    is_load    = ld;
    is_store   = !ld;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    rd_addr    = rd;
  endtask

  task automatic release_req();
    req_valid = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b0, 3'b010, 32'h40, 32'h1, 5'd1);
    @(negedge s_clk);
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++;
    if (done !== 1'b0 || wb_valid !== 1'b0) begin failures++; $display("FAIL rst_done_wb got=%b%b exp=00", done, wb_valid); end
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0) begin failures++; $display("FAIL rst_mem got=%b %h %b exp=0 0 0", mem_req, mem_addr, mem_be); end
    checks++;
    if (misaligned !== 1'b0 || exc_addr !== 32'h0 || wb_data !== 32'h0) begin failures++; $display("FAIL rst_exc got=%b %h %h exp=0", misaligned, exc_addr, wb_data); end
    checks++;
    release_req();
    step();
    s_reset = 1'b1;
    @(negedge s_clk);
    if (busy !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL rst_idle got=%b%b exp=00", busy, mem_req); end
    checks++;
  endtask

  task automatic test_sw();
    step();
    drive(1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0);
    @(negedge s_clk);
    if (busy !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL sw_accept busy/req got=%b%b exp=10", busy, mem_req); end
    checks++;
    step();
    mem_gnt = 1'b1;
    @(negedge s_clk);
    if (mem_req !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL sw_req req/we got=%b%b exp=11", mem_req, mem_we); end
    checks++;
    if (mem_addr !== 32'h100 || mem_be !== 4'b1111 || mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_bus got=%h %b %h exp=100 1111 deadbeef", mem_addr, mem_be, mem_wdata); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL sw_early_done got=%b exp=0", done); end
    checks++;
    step();
    mem_gnt = 1'b0;
    release_req();
    @(negedge s_clk);
    if (done !== 1'b1 || wb_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL sw_done done/wb/busy got=%b%b%b exp=100", done, wb_valid, busy); end
    checks++;
  endtask

  task automatic test_sb_back_to_back();
    step();
    drive(1'b0, 3'b000, 32'h203, 32'h000000A5, 5'd0);
    step();
    mem_gnt = 1'b1;
    @(negedge s_clk);
    if (mem_addr !== 32'h200 || mem_be !== 4'b1000 || mem_wdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL sb_bus got=%h %b %h exp=200 1000 a5a5a5a5", mem_addr, mem_be, mem_wdata); end
    checks++;
    step();
    mem_gnt = 1'b0;
    release_req();
    @(negedge s_clk);
    if (done !== 1'b1) begin failures++; $display("FAIL sb_done got=%b exp=1", done); end
    checks++;
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s  [2] = '{3'b000, 3'b100};
    logic [31:0] exps [2] = '{32'hFFFFFF80, 32'h00000080};
    for (int i = 0; i < 2; i++) begin
      step();
      drive(1'b1, f3s[i], 32'h101, 32'h0, 5'd9);
      step();
      mem_gnt = 1'b1;
      @(negedge s_clk);
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin failures++; $display("FAIL ld%0d_req got=%b%b %h exp=10 100", i, mem_req, mem_we, mem_addr); end
      checks++;
      step();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h12348056;
      @(negedge s_clk);
      if (mem_req !== 1'b0 || busy !== 1'b1 || wb_valid !== 1'b0) begin failures++; $display("FAIL ld%0d_wait got=%b%b%b exp=010", i, mem_req, busy, wb_valid); end
      checks++;
      step();
      mem_rvalid = 1'b0;
      release_req();
      @(negedge s_clk);
      if (wb_valid !== 1'b1 || done !== 1'b1 || wb_rd !== 5'd9) begin failures++; $display("FAIL ld%0d_wb got=%b%b %0d exp=11 9", i, wb_valid, done, wb_rd); end
      checks++;
      if (wb_data !== exps[i]) begin failures++; $display("FAIL ld%0d_data got=%h exp=%h", i, wb_data, exps[i]); end
      checks++;
    end
  endtask

  task automatic test_gnt_delay();
    step();
    drive(1'b1, 3'b001, 32'h102, 32'h0, 5'd7);
    @(negedge s_clk);
    if (busy !== 1'b1) begin failures++; $display("FAIL lh_accept_busy got=%b exp=1", busy); end
    checks++;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge s_clk);
      if (mem_req !== 1'b1 || mem_addr !== 32'h100 || busy !== 1'b1) begin failures++; $display("FAIL lh_stall%0d got=%b %h %b exp=1 100 1", k, mem_req, mem_addr, busy); end
      checks++;
    end
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h80011234;
    @(negedge s_clk);
    if (busy !== 1'b1 || mem_req !== 1'b0 || wb_valid !== 1'b0) begin failures++; $display("FAIL lh_wait got=%b%b%b exp=100", busy, mem_req, wb_valid); end
    checks++;
    step();
    mem_rvalid = 1'b0;
    release_req();
    @(negedge s_clk);
    if (wb_valid !== 1'b1 || wb_data !== 32'hFFFF8001 || wb_rd !== 5'd7) begin failures++; $display("FAIL lh_wb got=%b %h %0d exp=1 ffff8001 7", wb_valid, wb_data, wb_rd); end
    checks++;
  endtask

  task automatic test_misalign();
    step();
    drive(1'b1, 3'b010, 32'h102, 32'h0, 5'd4);
    @(negedge s_clk);
    if (mem_req !== 1'b0) begin failures++; $display("FAIL mis_accept_req got=%b exp=0", mem_req); end
    checks++;
`ifdef LSU_MISALIGN_TRAP_EN
    step();
    release_req();
    @(negedge s_clk);
    if (misaligned !== 1'b1 || exc_addr !== 32'h102) begin failures++; $display("FAIL mis_trap got=%b %h exp=1 102", misaligned, exc_addr); end
    checks++;
    if (mem_req !== 1'b0 || wb_valid !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL mis_done got=%b%b%b exp=001", mem_req, wb_valid, done); end
    checks++;
    step();
    @(negedge s_clk);
    if (misaligned !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL mis_clear got=%b%b exp=00", misaligned, mem_req); end
    checks++;
`else
    step();
    mem_gnt = 1'b1;
    @(negedge s_clk);
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin failures++; $display("FAIL mis_req got=%b %h exp=1 100", mem_req, mem_addr); end
    checks++;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFEF00D;
    step();
    mem_rvalid = 1'b0;
    release_req();
    @(negedge s_clk);
    if (misaligned !== 1'b0 || exc_addr !== 32'h0) begin failures++; $display("FAIL mis_flag got=%b %h exp=0 0", misaligned, exc_addr); end
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'hCAFEF00D) begin failures++; $display("FAIL mis_wb got=%b %h exp=1 cafef00d", wb_valid, wb_data); end
    checks++;
`endif
  endtask

  task automatic test_illegal();
    step();
    drive(1'b0, 3'b011, 32'h300, 32'h55, 5'd0);
    step();
    release_req();
    @(negedge s_clk);
    if (done !== 1'b1 || mem_req !== 1'b0 || wb_valid !== 1'b0) begin failures++; $display("FAIL illegal got=%b%b%b exp=100", done, mem_req, wb_valid); end
    checks++;
  endtask

  task automatic test_reset_mid();
    step();
    drive(1'b1, 3'b010, 32'h100, 32'h0, 5'd3);
    step();
    @(negedge s_clk);
    #2;
    s_reset = 1'b0;
    #1;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_req_drop got=%b%b exp=00", mem_req, busy); end
    checks++;
    release_req();
    step();
    s_reset = 1'b1;
    step();
    drive(1'b1, 3'b010, 32'h100, 32'h0, 5'd3);
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    @(negedge s_clk);
    if (busy !== 1'b1) begin failures++; $display("FAIL rstw_pre_busy got=%b exp=1", busy); end
    checks++;
    #2;
    s_reset = 1'b0;
    #1;
    if (mem_req !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0) begin failures++; $display("FAIL rstw_drop got=%b%b%b exp=000", mem_req, busy, wb_valid); end
    checks++;
    release_req();
    step();
    s_reset = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11111111;
    @(negedge s_clk);
    if (wb_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstw_stray got=%b%b exp=00", wb_valid, busy); end
    checks++;
    step();
    mem_rvalid = 1'b0;
    @(negedge s_clk);
    if (wb_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstw_after got=%b%b exp=00", wb_valid, done); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb_back_to_back();
    test_load_ext();
    test_gnt_delay();
    test_misalign();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
